// File: rtl/conv_group_sched.sv
// Sequencer for the P-lane convolution datapath: loads x over a stream, issues
// grouped MAC schedules, then drains y while the next x vector may be loading.
module conv_group_sched #(
    parameter int LENX    = 8,
    parameter int LENF    = 4,
    parameter int P       = 3,
    parameter int ADDRX   = 3,
    parameter int ADDRF   = 2,
    parameter int SIZE    = LENX - LENF + 1,
    parameter int LOGSIZE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid_x,
    output logic               s_ready_x,
    output logic               x_wr_en,
    output logic [ADDRX-1:0]   x_wr_addr,
    output logic [ADDRX-1:0]   x_rd_base,
    output logic [ADDRF-1:0]   f_rd_addr,
    output logic [P-1:0]       clr_acc,
    output logic [P-1:0]       en_acc,
    output logic               y_wr_en,
    output logic [LOGSIZE-1:0] y_wr_addr,
    output logic [P-1:0]       y_lane_mask,
    output logic [LOGSIZE-1:0] y_rd_addr,
    output logic               m_valid_y,
    input  logic               m_ready_y
);

    localparam int NG  = (SIZE + P - 1) / P;
    localparam int XCW = $clog2(LENX + 1);
    localparam int CW  = $clog2(LENF + 2);
    localparam int GW  = (NG > 1) ? $clog2(NG) : 1;

    localparam logic [XCW-1:0]     X_FULL     = XCW'(LENX);
    localparam logic [CW-1:0]      C_ISSUE    = CW'(LENF);
    localparam logic [CW-1:0]      C_ISSUE_HI = CW'(LENF - 1);
    localparam logic [CW-1:0]      C_LAST     = CW'(LENF + 1);
    localparam logic [GW-1:0]      G_LAST     = GW'(NG - 1);
    localparam logic [LOGSIZE-1:0] RD_LAST    = LOGSIZE'(SIZE - 1);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [XCW-1:0]       x_cnt_q, x_cnt_d;
    logic [CW-1:0]        c_q, c_d;
    logic [GW-1:0]        g_q, g_d;
    logic [LOGSIZE-1:0]   rd_idx_q, rd_idx_d;
    logic                 data_ok_q, data_ok_d;

    logic [LOGSIZE-1:0]   base;
    logic [P-1:0]         mask;
    logic [CW-1:0]        c_issue;
    logic                 in_compute;
    logic                 y_hs;

    // Group geometry: lanes past the last output are masked off.
    always_comb begin
        base = LOGSIZE'(int'(g_q) * P);
        for (int i = 0; i < P; i++) begin
            mask[i] = (int'(g_q) * P + i) < SIZE;
        end
    end

    always_comb begin
        in_compute  = (state_q == COMPUTE);
        s_ready_x   = (x_cnt_q < X_FULL) && (state_q != COMPUTE);
        x_wr_en     = s_valid_x && s_ready_x;
        x_wr_addr   = x_cnt_q[ADDRX-1:0];
        // Addresses hold the last issued tap during the accumulate/write tail.
        c_issue     = (c_q < C_ISSUE) ? c_q : C_ISSUE_HI;
        f_rd_addr   = ADDRF'(c_issue);
        x_rd_base   = ADDRX'(int'(base) + int'(c_issue));
        clr_acc     = (in_compute && c_q == '0) ? '1 : '0;
        en_acc      = (in_compute && c_q != '0 && c_q <= C_ISSUE) ? mask : '0;
        y_wr_en     = in_compute && (c_q == C_LAST);
        y_wr_addr   = base;
        y_lane_mask = y_wr_en ? mask : '0;
        y_rd_addr   = rd_idx_q;
        m_valid_y   = (state_q == DRAIN) && data_ok_q;
        y_hs        = m_valid_y && m_ready_y;
    end

    // NOTE: every next-state variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        c_d       = c_q;
        g_d       = g_q;
        rd_idx_d  = rd_idx_q;
        data_ok_d = data_ok_q;

        if (x_wr_en) begin
            x_cnt_d = x_cnt_q + XCW'(1);
        end

        case (state_q)
            LOAD: begin
                if (x_cnt_q == X_FULL) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (g_q == G_LAST) begin
                        g_d       = '0;
                        x_cnt_d   = '0;
                        data_ok_d = 1'b0;
                        state_d   = DRAIN;
                    end else begin
                        g_d = g_q + GW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            DRAIN: begin
                // y read latency is one cycle, so valid follows each new address by one cycle.
                if (!data_ok_q) begin
                    data_ok_d = 1'b1;
                end
                if (y_hs) begin
                    data_ok_d = 1'b0;
                    if (rd_idx_q == RD_LAST) begin
                        rd_idx_d = '0;
                        state_d  = (x_cnt_d == X_FULL) ? COMPUTE : LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + LOGSIZE'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: reset is in the sensitivity list so an abort takes effect without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD;
            x_cnt_q   <= '0;
            c_q       <= '0;
            g_q       <= '0;
            rd_idx_q  <= '0;
            data_ok_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values regardless of statement order.
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            c_q       <= c_d;
            g_q       <= g_d;
            rd_idx_q  <= rd_idx_d;
            data_ok_q <= data_ok_d;
        end
    end

endmodule

// File: tb/tb_conv_group_sched.sv
// Self-checking bench for conv_group_sched: table-driven compute schedule plus
// scoreboards for x write addresses and y read addresses.
module tb_conv_group_sched;

    localparam int LENX    = 8;
    localparam int LENF    = 4;
    localparam int P       = 3;
    localparam int ADDRX   = 3;
    localparam int ADDRF   = 2;
    localparam int SIZE    = 5;
    localparam int LOGSIZE = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid_x;
    logic               s_ready_x;
    logic               x_wr_en;
    logic [ADDRX-1:0]   x_wr_addr;
    logic [ADDRX-1:0]   x_rd_base;
    logic [ADDRF-1:0]   f_rd_addr;
    logic [P-1:0]       clr_acc;
    logic [P-1:0]       en_acc;
    logic               y_wr_en;
    logic [LOGSIZE-1:0] y_wr_addr;
    logic [P-1:0]       y_lane_mask;
    logic [LOGSIZE-1:0] y_rd_addr;
    logic               m_valid_y;
    logic               m_ready_y;

    always #5 clk = ~clk;

    conv_group_sched #(
        .LENX(LENX), .LENF(LENF), .P(P), .ADDRX(ADDRX), .ADDRF(ADDRF),
        .SIZE(SIZE), .LOGSIZE(LOGSIZE)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr),
        .x_rd_base(x_rd_base), .f_rd_addr(f_rd_addr),
        .clr_acc(clr_acc), .en_acc(en_acc),
        .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_lane_mask(y_lane_mask),
        .y_rd_addr(y_rd_addr), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
    );

    typedef struct {
        logic       s_valid;
        logic [2:0] clr;
        logic [2:0] en;
        logic       issue;
        logic [1:0] f;
        logic [2:0] xb;
        logic       ywe;
        logic [2:0] ywa;
        logic [2:0] mask;
    } cvec_t;

    cvec_t      ctab [12];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] xq [$];
    logic [2:0] yq [$];
    int         hs_x;
    int         hs_y;
    logic       stall_pend;
    logic [2:0] stall_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor, called mid-cycle away from the rising edge.
    task automatic sample();
        if (x_wr_en) begin
            hs_x++;
            if (xq.size() == 0) check("x_unexpected", x_wr_en, 0);
            else                check("x_wr_addr", x_wr_addr, xq.pop_front());
        end
        if (stall_pend) begin
            check("y_stall_valid", m_valid_y, 1);
            check("y_stall_addr", y_rd_addr, stall_addr);
        end
        if (m_valid_y && m_ready_y) begin
            hs_y++;
            if (yq.size() == 0) check("y_unexpected", m_valid_y, 0);
            else                check("y_rd_addr", y_rd_addr, yq.pop_front());
        end
        stall_pend = m_valid_y && !m_ready_y;
        stall_addr = y_rd_addr;
    endtask

    task automatic run_compute(input int n);
        for (int k = 0; k < n; k++) begin
            s_valid_x = ctab[k].s_valid;
            m_ready_y = 1'b1;
            #2;
            check($sformatf("clr_acc[%0d]", k), clr_acc, ctab[k].clr);
            check($sformatf("en_acc[%0d]", k), en_acc, ctab[k].en);
            if (ctab[k].issue) begin
                check($sformatf("f_rd_addr[%0d]", k), f_rd_addr, ctab[k].f);
                check($sformatf("x_rd_base[%0d]", k), x_rd_base, ctab[k].xb);
            end
            check($sformatf("y_wr_en[%0d]", k), y_wr_en, ctab[k].ywe);
            check($sformatf("y_lane_mask[%0d]", k), y_lane_mask, ctab[k].mask);
            if (ctab[k].ywe) check($sformatf("y_wr_addr[%0d]", k), y_wr_addr, ctab[k].ywa);
            check($sformatf("s_ready_compute[%0d]", k), s_ready_x, 0);
            check($sformatf("m_valid_compute[%0d]", k), m_valid_y, 0);
            sample();
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            valid clr     en      iss f     xb    ywe ywa   mask
        ctab[0]  = '{1'b1, 3'b111, 3'b000, 1'b1, 2'd0, 3'd0, 1'b0, 3'd0, 3'b000};
        ctab[1]  = '{1'b1, 3'b000, 3'b111, 1'b1, 2'd1, 3'd1, 1'b0, 3'd0, 3'b000};
        ctab[2]  = '{1'b1, 3'b000, 3'b111, 1'b1, 2'd2, 3'd2, 1'b0, 3'd0, 3'b000};
        ctab[3]  = '{1'b1, 3'b000, 3'b111, 1'b1, 2'd3, 3'd3, 1'b0, 3'd0, 3'b000};
        ctab[4]  = '{1'b1, 3'b000, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0, 3'd0, 3'b000};
        ctab[5]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'd0, 1'b1, 3'd0, 3'b111};
        ctab[6]  = '{1'b1, 3'b111, 3'b000, 1'b1, 2'd0, 3'd3, 1'b0, 3'd0, 3'b000};
        ctab[7]  = '{1'b1, 3'b000, 3'b011, 1'b1, 2'd1, 3'd4, 1'b0, 3'd0, 3'b000};
        ctab[8]  = '{1'b1, 3'b000, 3'b011, 1'b1, 2'd2, 3'd5, 1'b0, 3'd0, 3'b000};
        ctab[9]  = '{1'b1, 3'b000, 3'b011, 1'b1, 2'd3, 3'd6, 1'b0, 3'd0, 3'b000};
        ctab[10] = '{1'b1, 3'b000, 3'b011, 1'b0, 2'd0, 3'd0, 1'b0, 3'd0, 3'b000};
        ctab[11] = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'd0, 1'b1, 3'd3, 3'b011};

        reset      = 1'b0;
        s_valid_x  = 1'b0;
        m_ready_y  = 1'b0;
        stall_pend = 1'b0;
        stall_addr = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_s_ready", s_ready_x, 1);
        check("rst_x_wr_en", x_wr_en, 0);
        check("rst_x_wr_addr", x_wr_addr, 0);
        check("rst_x_rd_base", x_rd_base, 0);
        check("rst_f_rd_addr", f_rd_addr, 0);
        check("rst_clr_acc", clr_acc, 0);
        check("rst_en_acc", en_acc, 0);
        check("rst_y_wr_en", y_wr_en, 0);
        check("rst_y_wr_addr", y_wr_addr, 0);
        check("rst_y_lane_mask", y_lane_mask, 0);
        check("rst_y_rd_addr", y_rd_addr, 0);
        check("rst_m_valid", m_valid_y, 0);
        @(negedge clk);
        reset = 1'b0;

        // Load with valid held for 9 cycles: 8 accepted, then full.
        hs_x = 0;
        for (int i = 0; i < 8; i++) xq.push_back(3'(i));
        for (int i = 0; i < 9; i++) begin
            s_valid_x = 1'b1;
            #2;
            check($sformatf("load_ready[%0d]", i), s_ready_x, (i < 8));
            check($sformatf("load_no_clr[%0d]", i), clr_acc, 0);
            sample();
            @(negedge clk);
        end
        check("load_hs", hs_x, 8);
        run_compute(12);

        // Drain with a stalling consumer; no new x words.
        hs_y = 0;
        for (int i = 0; i < SIZE; i++) yq.push_back(3'(i));
        s_valid_x = 1'b0;
        begin
            int pat [7];
            pat = '{1, 0, 0, 1, 1, 0, 1};
            for (int t = 0; t < 60 && hs_y < SIZE; t++) begin
                m_ready_y = pat[t % 7] != 0;
                #2;
                sample();
                @(negedge clk);
            end
        end
        check("drain_hs", hs_y, SIZE);
        for (int t = 0; t < 3; t++) begin
            m_ready_y = 1'b1;
            #2;
            check($sformatf("idle_valid[%0d]", t), m_valid_y, 0);
            check($sformatf("idle_clr[%0d]", t), clr_acc, 0);
            check($sformatf("idle_ready[%0d]", t), s_ready_x, 1);
            sample();
            @(negedge clk);
        end

        // Load with valid toggling: exactly one LOAD cycle after the 8th word.
        hs_x = 0;
        for (int i = 0; i < 8; i++) xq.push_back(3'(i));
        for (int t = 0; t < 16; t++) begin
            s_valid_x = (t % 2 == 0);
            #2;
            check($sformatf("toggle_no_clr[%0d]", t), clr_acc, 0);
            if (t == 15) check("gap_ready", s_ready_x, 0);
            sample();
            @(negedge clk);
        end
        check("toggle_hs", hs_x, 8);
        run_compute(12);

        // Drain at full rate while the next vector streams in early.
        hs_x = 0;
        hs_y = 0;
        for (int i = 0; i < 8; i++) xq.push_back(3'(i));
        for (int i = 0; i < SIZE; i++) yq.push_back(3'(i));
        for (int t = 0; t < 40 && hs_y < SIZE; t++) begin
            s_valid_x = 1'b1;
            m_ready_y = 1'b1;
            #2;
            check($sformatf("overlap_ready[%0d]", t), s_ready_x, (hs_x < 8));
            sample();
            @(negedge clk);
        end
        check("overlap_hs_x", hs_x, 8);
        check("overlap_hs_y", hs_y, SIZE);
        run_compute(12);

        // 8th x word lands on the same edge as the final y handshake.
        hs_x = 0;
        hs_y = 0;
        for (int i = 0; i < 8; i++) xq.push_back(3'(i));
        for (int i = 0; i < SIZE; i++) yq.push_back(3'(i));
        for (int t = 0; t < 40 && hs_y < SIZE; t++) begin
            s_valid_x = (t >= 2);
            m_ready_y = 1'b1;
            #2;
            if (m_valid_y && y_rd_addr == 3'(SIZE - 1)) check("coincident_x_hs", x_wr_en, 1);
            sample();
            @(negedge clk);
        end
        check("coincide_hs_x", hs_x, 8);
        check("coincide_hs_y", hs_y, SIZE);

        // Asynchronous abort in group 1, c=2.
        run_compute(8);
        s_valid_x = 1'b0;
        #2;
        check("pre_reset_en", en_acc, 3'b011);
        reset = 1'b1;
        #1;
        check("abort_en_acc", en_acc, 0);
        check("abort_clr_acc", clr_acc, 0);
        check("abort_y_wr_en", y_wr_en, 0);
        check("abort_m_valid", m_valid_y, 0);
        check("abort_s_ready", s_ready_x, 1);
        @(negedge clk);
        reset      = 1'b0;
        stall_pend = 1'b0;

        hs_x = 0;
        for (int i = 0; i < 7; i++) xq.push_back(3'(i));
        for (int t = 0; t < 7; t++) begin
            s_valid_x = 1'b1;
            #2;
            sample();
            @(negedge clk);
        end
        for (int t = 0; t < 4; t++) begin
            s_valid_x = 1'b0;
            #2;
            check($sformatf("partial_no_clr[%0d]", t), clr_acc, 0);
            check($sformatf("partial_ready[%0d]", t), s_ready_x, 1);
            sample();
            @(negedge clk);
        end
        xq.push_back(3'd7);
        s_valid_x = 1'b1;
        #2;
        sample();
        @(negedge clk);
        s_valid_x = 1'b0;
        #2;
        check("refill_gap_clr", clr_acc, 0);
        sample();
        @(negedge clk);
        check("refill_hs", hs_x, 8);
        run_compute(12);

        check("xq_empty", xq.size(), 0);
        check("yq_empty", yq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
